// File: rtl/disp_sseg_seq.sv
// Sequential double-dabble seven-segment driver with load/busy/done handshake.
// Define DISP_SSEG_LZB_EN to enable leading-zero blanking in decimal and hex modes.
module disp_sseg_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      x,
  input  logic [1:0]            mode,
  input  logic                  load,
  input  logic                  enable,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [7*DIGITS-1:0]   segs
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  typedef enum logic [1:0] {MODE_SDEC = 2'b00, MODE_HEX = 2'b01,
                            MODE_BIN = 2'b10, MODE_UDEC = 2'b11} mode_t;

  state_t              state;
  mode_t               mode_q;
  logic                neg_q;
  logic [WIDTH-1:0]    x_q;
  logic [WIDTH-1:0]    sh;
  logic [BW-1:0]       bcd;
  logic                bcd_ovf;
  logic [CW-1:0]       cnt;
  logic [7*DIGITS-1:0] result_q;

  logic [WIDTH-1:0]    mag;
  logic [BW-1:0]       adj;
  logic [BW-1:0]       bcd_nx;
  logic [WIDTH-1:0]    sh_nx;
  logic                carry;
  logic [31:0]         xp;
  logic [7*DIGITS-1:0] res_segs;
  logic                res_ovf;
  int unsigned         dec_sig;
  int unsigned         hex_sig;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    mag = (mode == 2'b00 && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  end

  // A bit shifted out of the top nibble means the value needs more than DIGITS digits.
  always_comb begin
    adj = bcd;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
    end
    carry  = adj[BW-1];
    bcd_nx = {adj[BW-2:0], sh[WIDTH-1]};
    sh_nx  = {sh[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    xp       = 32'(x_q);
    res_segs = '1;
    res_ovf  = 1'b0;
    dec_sig  = 1;
    hex_sig  = 1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] != 4'd0) dec_sig = d + 1;
      if (xp[4*d +: 4] != 4'd0)  hex_sig = d + 1;
    end
    case (mode_q)
      MODE_HEX: begin
        res_ovf = |(xp >> BW);
        for (int unsigned d = 0; d < DIGITS; d++) begin
`ifdef DISP_SSEG_LZB_EN
          res_segs[7*d +: 7] = (d < hex_sig) ? seg7(xp[4*d +: 4]) : SEG_BLANK;
`else
          res_segs[7*d +: 7] = seg7(xp[4*d +: 4]);
`endif
        end
      end
      MODE_BIN: begin
        for (int unsigned d = 0; d < DIGITS; d++) begin
          res_segs[7*d +: 7] = seg7({2'b00, xp[2*d +: 2]});
        end
      end
      default: begin
        res_ovf = bcd_ovf || (neg_q && bcd[BW-1 -: 4] != 4'd0);
        for (int unsigned d = 0; d < DIGITS; d++) begin
`ifdef DISP_SSEG_LZB_EN
          if (d < dec_sig)              res_segs[7*d +: 7] = seg7(bcd[4*d +: 4]);
          else if (neg_q && d == dec_sig) res_segs[7*d +: 7] = SEG_MINUS;
          else                          res_segs[7*d +: 7] = SEG_BLANK;
`else
          if (neg_q && d == DIGITS - 1) res_segs[7*d +: 7] = SEG_MINUS;
          else                          res_segs[7*d +: 7] = seg7(bcd[4*d +: 4]);
`endif
        end
      end
    endcase
    if (res_ovf) res_segs = {DIGITS{SEG_MINUS}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      segs     <= '1;
      result_q <= '1;
      mode_q   <= MODE_SDEC;
      neg_q    <= 1'b0;
      x_q      <= '0;
      sh       <= '0;
      bcd      <= '0;
      bcd_ovf  <= 1'b0;
      cnt      <= '0;
    end else begin
      busy <= (state != IDLE);
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            mode_q  <= mode_t'(mode);
            neg_q   <= (mode == 2'b00) && x[WIDTH-1];
            x_q     <= x;
            sh      <= mag;
            bcd     <= '0;
            bcd_ovf <= 1'b0;
            cnt     <= '0;
            state   <= CONV;
          end
        end
        CONV: begin
          sh      <= sh_nx;
          bcd     <= bcd_nx;
          bcd_ovf <= bcd_ovf | carry;
          cnt     <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          result_q <= res_segs;
          ovf      <= res_ovf;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // The fresh result bypasses result_q so segs and done move on the same edge.
      if (!enable)            segs <= '1;
      else if (state == DONE) segs <= res_segs;
      else                    segs <= result_q;
    end
  end

endmodule

// File: tb/tb_disp_sseg_seq.sv
// Directed self-checking bench for disp_sseg_seq (8-bit/4-digit and 16-bit/4-digit instances).
module tb_disp_sseg_seq;

  localparam logic [6:0] BL = 7'h7F, MI = 7'h3F;
  localparam logic [6:0] D0 = 7'h40, D1 = 7'h79, D2 = 7'h24, D3 = 7'h30, D4 = 7'h19;
  localparam logic [6:0] D5 = 7'h12, D7 = 7'h78, D8 = 7'h00, D9 = 7'h10, DA = 7'h08, DF = 7'h0E;
`ifdef DISP_SSEG_LZB_EN
  localparam logic [6:0] LZ = BL;
`else
  localparam logic [6:0] LZ = D0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  x8;
  logic [1:0]  mode8;
  logic        load8, busy8, done8, ovf8;
  logic [27:0] segs8;
  logic [15:0] x16;
  logic [1:0]  mode16;
  logic        load16, busy16, done16, ovf16;
  logic [27:0] segs16;

  int n_checks = 0;
  int n_errors = 0;

  disp_sseg_seq #(.WIDTH(8), .DIGITS(4)) u_dut8 (
    .clk(clk), .reset(reset), .x(x8), .mode(mode8), .load(load8), .enable(enable),
    .busy(busy8), .done(done8), .ovf(ovf8), .segs(segs8)
  );

  disp_sseg_seq #(.WIDTH(16), .DIGITS(4)) u_dut16 (
    .clk(clk), .reset(reset), .x(x16), .mode(mode16), .load(load16), .enable(enable),
    .busy(busy16), .done(done16), .ovf(ovf16), .segs(segs16)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] s4(input logic [6:0] a, input logic [6:0] b,
                                     input logic [6:0] c, input logic [6:0] d);
    return {a, b, c, d};
  endfunction

  task automatic load_a(input logic [7:0] v, input logic [1:0] m);
    x8 = v; mode8 = m; load8 = 1'b1;
    tick();
    load8 = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int got = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done8) begin got = 1; break; end
    end
    check({tag, "_done"}, got, 1);
  endtask

  task automatic run_a(input string tag, input logic [7:0] v, input logic [1:0] m,
                       input logic [27:0] exp_segs, input logic exp_ovf);
    load_a(v, m);
    wait_done_a(tag);
    check({tag, "_segs"}, segs8, exp_segs);
    check({tag, "_ovf"}, ovf8, exp_ovf);
  endtask

  task automatic run_b(input string tag, input logic [15:0] v, input logic [1:0] m,
                       input logic [27:0] exp_segs, input logic exp_ovf);
    int got = 0;
    x16 = v; mode16 = m; load16 = 1'b1;
    tick();
    load16 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done16) begin got = 1; break; end
    end
    check({tag, "_done"}, got, 1);
    check({tag, "_segs"}, segs16, exp_segs);
    check({tag, "_ovf"}, ovf16, exp_ovf);
  endtask

  initial begin
    int n_done;
    reset = 1'b1; enable = 1'b1;
    x8 = '0; mode8 = '0; load8 = 1'b0;
    x16 = '0; mode16 = '0; load16 = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_segs", segs8, 28'hFFFFFFF);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_ovf", ovf8, 0);

    // Exact handshake timing around a -128 conversion.
    load_a(8'h80, 2'b00);
    check("t_busy_k", busy8, 0);
    tick();
    check("t_busy_k1", busy8, 1);
    repeat (7) tick();
    check("t_done_k8", done8, 0);
    tick();
    check("t_done_k9", done8, 1);
    check("t_segs_k9", segs8, s4(MI, D1, D2, D8));
    check("t_ovf_k9", ovf8, 0);
    check("t_busy_k9", busy8, 1);
    tick();
    check("t_busy_k10", busy8, 0);
    check("t_done_k10", done8, 0);

    run_a("zero", 8'h00, 2'b00, s4(LZ, LZ, LZ, D0), 1'b0);
    run_a("hex_af", 8'hAF, 2'b01, s4(LZ, LZ, DA, DF), 1'b0);
    run_a("udec_255", 8'hFF, 2'b11, s4(LZ, D2, D5, D5), 1'b0);
    run_a("bin_e4", 8'hE4, 2'b10, s4(D3, D2, D1, D0), 1'b0);
    run_a("sdec_7", 8'h07, 2'b00, s4(LZ, LZ, LZ, D7), 1'b0);
`ifdef DISP_SSEG_LZB_EN
    run_a("sdec_m5", 8'hFB, 2'b00, s4(BL, BL, MI, D5), 1'b0);
`else
    run_a("sdec_m5", 8'hFB, 2'b00, s4(MI, D0, D0, D5), 1'b0);
`endif

    // A second load while busy must be dropped, not queued.
    load_a(8'd42, 2'b11);
    tick(); tick();
    x8 = 8'd99; load8 = 1'b1;
    tick();
    load8 = 1'b0;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done8) n_done++;
    end
    check("ign_ndone", n_done, 1);
    check("ign_segs", segs8, s4(LZ, LZ, D4, D2));

    load_a(8'd7, 2'b11);
    tick();
    enable = 1'b0;
    tick();
    check("en_blank", segs8, 28'hFFFFFFF);
    check("en_busy", busy8, 1);
    wait_done_a("en");
    check("en_blank_done", segs8, 28'hFFFFFFF);
    enable = 1'b1;
    tick();
    check("en_restore", segs8, s4(LZ, LZ, LZ, D7));

    load_a(8'd55, 2'b11);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_segs", segs8, 28'hFFFFFFF);
    check("mrst_busy", busy8, 0);
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done8) n_done++;
    end
    check("mrst_ndone", n_done, 0);
    check("mrst_segs_after", segs8, 28'hFFFFFFF);

    run_b("w16_m1000", 16'hFC18, 2'b00, s4(MI, MI, MI, MI), 1'b1);
    run_b("w16_m999", 16'hFC19, 2'b00, s4(MI, D9, D9, D9), 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
